// File: rtl/ms_pkg.sv
// Shared constants and FSM encoding for the multiplier-switch array and its neighbours.
package ms_pkg;
    localparam int DATA_W   = 16;
    localparam int MS_OUT_W = 32;
    localparam int MULT_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } ms_state_e;
endpackage

// File: rtl/ms_array_ctrl_if.sv
// Operand handshakes from the distribution network plus the drive bus into the switch row.
interface ms_array_ctrl_if import ms_pkg::*; #(
    parameter int NUM_MS = 16,
    parameter int DATA_W = ms_pkg::DATA_W
);
    logic                     stat_valid;
    logic                     stat_ready;
    logic [NUM_MS*DATA_W-1:0] stat_data;
    logic                     strm_valid;
    logic                     strm_ready;
    logic [NUM_MS*DATA_W-1:0] strm_data;
    logic [NUM_MS-1:0]        ms_valid;
    logic                     ms_stationary;
    logic [NUM_MS*DATA_W-1:0] ms_data;

    modport master (
        output stat_valid, stat_data, strm_valid, strm_data,
        input  stat_ready, strm_ready, ms_valid, ms_stationary, ms_data
    );

    modport slave (
        input  stat_valid, stat_data, strm_valid, strm_data,
        output stat_ready, strm_ready, ms_valid, ms_stationary, ms_data
    );
endinterface

// File: rtl/ms_issue_reg.sv
// Registered drive stage into the switch row: at most one issue per cycle, per-lane valid gated by the enable mask.
module ms_issue_reg import ms_pkg::*; #(
    parameter int NUM_MS = 16,
    parameter int DATA_W = ms_pkg::DATA_W
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     issue,
    input  logic                     stationary,
    input  logic [NUM_MS-1:0]        mask,
    input  logic [NUM_MS*DATA_W-1:0] data,
    output logic [NUM_MS-1:0]        ms_valid,
    output logic                     ms_stationary,
    output logic [NUM_MS*DATA_W-1:0] ms_data
);
    always_ff @(posedge CLK) begin
        if (rst) ms_stationary <= 1'b0;
        else     ms_stationary <= issue & stationary;
    end

    // Idle cycles drive zero data so disabled or bubbled lanes see a quiet bus.
    for (genvar k = 0; k < NUM_MS; k++) begin : g_lane
        always_ff @(posedge CLK) begin
            if (rst) begin
                ms_valid[k]                  <= 1'b0;
                ms_data[k*DATA_W +: DATA_W]  <= '0;
            end else begin
                ms_valid[k]                  <= issue & mask[k];
                ms_data[k*DATA_W +: DATA_W]  <= issue ? data[k*DATA_W +: DATA_W] : '0;
            end
        end
    end
endmodule

// File: rtl/ms_array_ctrl.sv
// Job sequencer for a row of multiplier switches: load one stationary vector, stream N vectors, drain, pulse done.
module ms_array_ctrl import ms_pkg::*; #(
    parameter int NUM_MS   = 16,
    parameter int DATA_W   = ms_pkg::DATA_W,
    parameter int CNT_W    = 16,
    parameter int MULT_LAT = ms_pkg::MULT_LAT
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_num_stream,
    input  logic [NUM_MS-1:0]    cfg_ms_en,
    ms_array_ctrl_if.slave       bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     prod_cnt
);
    localparam int DRAIN_W = $clog2(MULT_LAT + 2);

    ms_state_e           state, state_nxt;
    logic [CNT_W-1:0]    num_q;
    logic [NUM_MS-1:0]   en_q;
    logic [CNT_W-1:0]    rem, rem_nxt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                stat_hs, strm_hs;

    assign stat_hs = bus.stat_valid & bus.stat_ready;
    assign strm_hs = bus.strm_valid & bus.strm_ready;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    rem_nxt   = cfg_num_stream;
                end
            end
            ST_LOAD: begin
                if (stat_hs) state_nxt = (num_q == '0) ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: begin
                if (strm_hs) begin
                    rem_nxt = rem - 1'b1;
                    if (rem_nxt == '0) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state          <= ST_IDLE;
            num_q          <= '0;
            en_q           <= '0;
            rem            <= '0;
            drain_cnt      <= '0;
            prod_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.stat_ready <= 1'b0;
            bus.strm_ready <= 1'b0;
        end else begin
            state          <= state_nxt;
            rem            <= rem_nxt;
            busy           <= (state_nxt != ST_IDLE);
            done           <= (state_nxt == ST_DONE);
            bus.stat_ready <= (state_nxt == ST_LOAD);
            bus.strm_ready <= (state_nxt == ST_STREAM) && (rem_nxt != '0);

            if (state == ST_IDLE && start) begin
                num_q    <= cfg_num_stream;
                en_q     <= cfg_ms_en;
                prod_cnt <= '0;
            end else if (strm_hs) begin
                prod_cnt <= prod_cnt + 1'b1;
            end

            // Loaded on DRAIN entry, which coincides with the last issue landing on the switches.
            if (state != ST_DRAIN && state_nxt == ST_DRAIN)
                drain_cnt <= DRAIN_W'(MULT_LAT + 1);
            else if (state == ST_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    ms_issue_reg #(
        .NUM_MS (NUM_MS),
        .DATA_W (DATA_W)
    ) u_issue (
        .CLK           (CLK),
        .rst           (rst),
        .issue         (stat_hs | strm_hs),
        .stationary    (stat_hs),
        .mask          (en_q),
        .data          (stat_hs ? bus.stat_data : bus.strm_data),
        .ms_valid      (bus.ms_valid),
        .ms_stationary (bus.ms_stationary),
        .ms_data       (bus.ms_data)
    );
endmodule

// File: tb/tb_ms_array_ctrl.sv
// Scoreboard bench for ms_array_ctrl: the driver predicts switch issues and job results, a monitor checks them.
module tb_ms_array_ctrl;
    localparam int NUM_MS   = 4;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = 16;
    localparam int MULT_LAT = 2;

    typedef struct {
        logic [NUM_MS-1:0]        v;
        logic                     s;
        logic [NUM_MS*DATA_W-1:0] d;
    } exp_t;

    logic                CLK = 1'b0;
    logic                rst;
    logic                start;
    logic [CNT_W-1:0]    cfg_num_stream;
    logic [NUM_MS-1:0]   cfg_ms_en;
    logic                busy, done;
    logic [CNT_W-1:0]    prod_cnt;

    ms_array_ctrl_if #(.NUM_MS(NUM_MS), .DATA_W(DATA_W)) bus ();

    ms_array_ctrl #(
        .NUM_MS(NUM_MS), .DATA_W(DATA_W), .CNT_W(CNT_W), .MULT_LAT(MULT_LAT)
    ) dut (
        .CLK            (CLK),
        .rst            (rst),
        .start          (start),
        .cfg_num_stream (cfg_num_stream),
        .cfg_ms_en      (cfg_ms_en),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .prod_cnt       (prod_cnt)
    );

    always #5 CLK = ~CLK;

    exp_t exp_q[$];
    int   job_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   jobs_done = 0;
    int   cyc = 0, last_ms = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every switch issue must match the head of the scoreboard; done closes the oldest job.
    always @(negedge CLK) begin
        exp_t e;
        int   nj;
        cyc++;
        if (bus.ms_valid != '0 || bus.ms_stationary) begin
            last_ms = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {bus.ms_valid, bus.ms_stationary}, '0);
            end else begin
                e = exp_q.pop_front();
                chk("ms_valid", bus.ms_valid, e.v);
                chk("ms_stationary", bus.ms_stationary, e.s);
                chk("ms_data", bus.ms_data, e.d);
            end
        end else begin
            chk("idle_bus", {bus.ms_stationary, bus.ms_data}, '0);
        end
        if (done) begin
            if (job_q.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                nj = job_q.pop_front();
                chk("prod_cnt", prod_cnt, nj);
                chk("done_gap", cyc - last_ms, MULT_LAT + 2);
                chk("busy_at_done", busy, 1'b1);
                jobs_done++;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"}, {bus.stat_ready, bus.strm_ready}, '0);
        chk({tag, "_ms"}, {bus.ms_valid, bus.ms_stationary, bus.ms_data}, '0);
        chk({tag, "_status"}, {busy, done, prod_cnt}, '0);
    endtask

    // Runs one job from a negedge. bub = bubble percentage, pat = fixed 6-cycle stream valid pattern
    // (bit0 first) when use_pat, rst_after > 0 aborts with reset after that many accepted vectors.
    task automatic run_job(input int n, input logic [NUM_MS-1:0] m, input int bub,
                           input bit use_sd, input logic [63:0] sd,
                           input bit use_pat, input logic [5:0] pat,
                           input bit mid_start, input int rst_after);
        int   acc = 0, budget = 0, tail = 0, sc = 0, jd;
        bit   fired = 0, v;
        logic [63:0] d;
        jd = jobs_done;
        start = 1'b1; cfg_num_stream = CNT_W'(n); cfg_ms_en = m;
        job_q.push_back(n);
        @(negedge CLK);
        start = 1'b0; cfg_num_stream = CNT_W'($urandom); cfg_ms_en = NUM_MS'($urandom);
        d = use_sd ? sd : {$urandom, $urandom};
        bus.stat_data = d;
        forever begin
            bus.stat_valid = ($urandom_range(0, 99) >= bub);
            if (bus.stat_valid && bus.stat_ready) begin
                exp_q.push_back('{m, 1'b1, d});
                @(negedge CLK);
                break;
            end
            @(negedge CLK);
            if (++budget > 30) begin chk("load_timeout", 1'b0, 1'b1); break; end
        end
        bus.stat_valid = 1'b0;
        budget = 0;
        while (tail < 3) begin
            if (acc >= n)     v = 1'b1;
            else if (use_pat) v = (sc < 6) ? pat[sc] : 1'b1;
            else              v = ($urandom_range(0, 99) >= bub);
            d = {$urandom, $urandom};
            bus.strm_valid = v; bus.strm_data = d;
            start = 1'b0;
            if (mid_start && acc == 1 && !fired) begin
                fired = 1; start = 1'b1;
                cfg_num_stream = CNT_W'(n + 3); cfg_ms_en = '1;
            end
            if (v && bus.strm_ready) begin
                chk("over_accept", acc < n, 1'b1);
                exp_q.push_back('{m, 1'b0, d});
                acc++;
            end
            @(negedge CLK);
            sc++;
            if (rst_after > 0 && acc == rst_after) begin
                bus.strm_valid = 1'b0; start = 1'b0;
                rst = 1'b1;
                @(negedge CLK);
                chk_all_zero("midrst");
                chk("midrst_pending", exp_q.size(), 0);
                rst = 1'b0;
                job_q.delete(); exp_q.delete();
                repeat (8) @(negedge CLK);
                return;
            end
            if (acc >= n) tail++;
            if (++budget > 200) begin chk("stream_timeout", 1'b0, 1'b1); break; end
        end
        bus.strm_valid = 1'b0; start = 1'b0;
        chk("accepted", acc, n);
        budget = 0;
        while (jobs_done == jd && budget < 40) begin @(negedge CLK); budget++; end
        chk("done_seen", jobs_done - jd, 1);
        @(negedge CLK);
        chk("idle_after", {busy, done}, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_num_stream = '0; cfg_ms_en = '0;
        bus.stat_valid = 1'b0; bus.stat_data = '0;
        bus.strm_valid = 1'b0; bus.strm_data = '0;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge CLK);

        run_job(3, 4'hF, 0, 1, {16'd4, 16'd3, 16'd2, 16'd1}, 0, '0, 0, 0);
        run_job(2, 4'b0101, 0, 0, '0, 0, '0, 0, 0);
        run_job(3, 4'hF, 0, 0, '0, 1, 6'b101001, 0, 0);
        run_job(0, 4'hB, 0, 0, '0, 0, '0, 0, 0);
        chk("zero_len_prod_cnt", prod_cnt, '0);
        run_job(4, 4'h6, 20, 0, '0, 0, '0, 1, 0);
        run_job(5, 4'hF, 0, 0, '0, 0, '0, 0, 1);
        run_job(5, 4'h9, 0, 0, '0, 0, '0, 0, 0);
        for (int j = 0; j < 12; j++)
            run_job($urandom_range(1, 8), NUM_MS'($urandom_range(1, 15)), $urandom_range(0, 60),
                    0, '0, 0, '0, 0, 0);

        repeat (10) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("jobs_empty", job_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ms_array_ctrl.md
Name: ms_array_ctrl

Overview:
- Sequencer for a row of NUM_MS multiplier switches, each holding one stationary BF16 operand and multiplying it by a streamed BF16 operand.
- Per job: loads one stationary vector into all enabled switches, streams cfg_num_stream streaming vectors, waits for the multiplier pipeline to drain, then pulses done.
- Sits between the operand distribution network and the switch array.
- Owns all i_valid / i_stationary / i_data driving of the switches.

Parameters:
- NUM_MS, 16, number of multiplier switches driven.
- DATA_W, 16, operand width (BF16).
- CNT_W, 16, width of the streaming-vector counter.
- MULT_LAT, 2, cycles from switch input to valid product at the switch output.

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- cfg_num_stream  in  CNT_W  number of streaming vectors in the job; sampled with start.
- cfg_ms_en  in  NUM_MS  per-switch enable mask (sparse mapping); sampled with start.
- stat_valid  in  1  stationary vector valid.
- stat_ready  out  1  controller accepts stationary vector.
- stat_data  in  NUM_MS*DATA_W  stationary vector; lane k = bits [k*DATA_W +: DATA_W].
- strm_valid  in  1  streaming vector valid.
- strm_ready  out  1  controller accepts streaming vector.
- strm_data  in  NUM_MS*DATA_W  streaming vector.
- ms_valid  out  NUM_MS  per-switch i_valid.
- ms_stationary  out  1  broadcast i_stationary.
- ms_data  out  NUM_MS*DATA_W  per-switch i_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job end.
- prod_cnt  out  CNT_W  number of streaming vectors issued in the current or last job.

Behaviour:
- Reset: all outputs are registered and reset to 0 (including stat_ready, strm_ready, ms_*, busy, done, prod_cnt). FSM goes to IDLE. Reset mid-job aborts the job; no done pulse is produced.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 latches the config, clears prod_cnt and goes to LOAD.
  - start in any other state is ignored.
- LOAD:
  - stat_ready=1.
  - On a stat_valid & stat_ready handshake, next cycle: ms_valid=cfg_ms_en, ms_stationary=1, ms_data=stat_data for exactly one cycle.
  - Then go to STREAM; if cfg_num_stream==0, go directly to DRAIN instead.
- STREAM:
  - strm_ready=1 while remaining count > 0.
  - Each handshake produces, next cycle: ms_valid=cfg_ms_en, ms_stationary=0, ms_data=strm_data, and increments prod_cnt.
  - A cycle with no handshake drives ms_valid=0 and ms_data=0. Bubbles are allowed; there is no ordering constraint beyond handshake order.
  - On the handshake that brings the remaining count to 0, strm_ready drops in the same cycle as the state change to DRAIN. At most cfg_num_stream vectors are ever accepted.
- DRAIN:
  - Holds for MULT_LAT+1 cycles after the last ms_valid, using a down-counter, so the last switch product is valid.
  - Then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle the state enters IDLE.
- cfg_ms_en lanes that are 0 always see ms_valid=0, so a disabled switch never latches and never produces output.
- ms_stationary is never asserted together with stream data. Enabled switches therefore never multiply during LOAD on the first job. On later jobs a reload may produce a spurious product; downstream must ignore switch outputs while ms_stationary was high MULT_LAT cycles earlier. The controller exports nothing extra for this; it is documented for the reduction network.
- Throughput: one streaming vector per cycle with no bubbles. Job overhead is LOAD (≥1 cycle) + DRAIN (MULT_LAT+1) + DONE (1).
- prod_cnt saturates at cfg_num_stream; there is no wrap-around because acceptance stops at the limit.

Decomposition:
- Shared package ms_pkg:
  - FSM state encoding (ST_IDLE..ST_DONE, 3 bits).
  - Default widths DATA_W=16, MS_OUT_W=32.
  - MULT_LAT constant, shared with mult_switch and the reduction network.
- One natural sub-module, ms_issue_reg: the registered per-lane drive stage (valid gating by mask, data/stationary pipeline register, clear on rst).
- The FSM, counters and handshakes stay in ms_array_ctrl.

Test Plan:
- Basic job: NUM_MS=4, mask=4'hF, num_stream=3, stat=lanes{1,2,3,4}, 3 back-to-back stream vectors.
  - Expect exactly one ms_stationary=1 cycle with ms_valid=4'hF.
  - Then 3 cycles of ms_valid=4'hF and ms_stationary=0.
  - done asserts MULT_LAT+2 cycles after the last ms_valid; prod_cnt=3.
- Mask: mask=4'b0101, num_stream=2 -> ms_valid only ever 4'b0101; lanes 1 and 3 stay 0 for the whole job.
- Backpressure/bubbles: strm_valid toggles 1,0,0,1,0,1 with num_stream=3.
  - Expect 3 ms_valid pulses aligned one cycle after each handshake.
  - strm_ready=0 after the third handshake; a fourth strm_valid is not accepted.
- Zero-length job: num_stream=0 -> LOAD, DRAIN (MULT_LAT+1 cycles), done pulse; prod_cnt=0; no stream-phase ms_valid.
- Start while busy: a second start mid-STREAM is ignored; the job completes with the original cfg_num_stream and a single done pulse.
- Reset mid-job: assert rst in STREAM after 1 of 5 vectors.
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - A new start then runs a full job correctly.
